// File: rtl/image_streamer_if.sv
// Bundles the control, memory-read and pixel-stream signals of the image streamer.
// Ports: start/base_addr/pause (control in), mem_rd_en/mem_addr/mem_rd_data (memory read),
//        pixel_out/pixel_valid/row_last/frame_last (pixel stream), busy/done (status).
// master = streamer side, slave = environment (memory, sequencer and pixel sink).
interface image_streamer_if #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 10
) ();
    // Frame control
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  pause;

    // Synchronous-read memory port
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_SIZE-1:0]  mem_rd_data;

    // Pixel stream towards the window buffer
    logic [DATA_SIZE-1:0]  pixel_out;
    logic                  pixel_valid;
    logic                  row_last;
    logic                  frame_last;

    // Status
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, pause, mem_rd_data,
        output mem_rd_en, mem_addr,
        output pixel_out, pixel_valid, row_last, frame_last,
        output busy, done
    );

    modport slave (
        output start, base_addr, pause, mem_rd_data,
        input  mem_rd_en, mem_addr,
        input  pixel_out, pixel_valid, row_last, frame_last,
        input  busy, done
    );
endinterface

// File: rtl/image_streamer.sv
// Purpose: raster-order pixel source; reads ROW_SIZE x COLUMN_SIZE pixels from a sync-read memory.
// Latency: read issued in cycle t -> pixel_out/pixel_valid with row/frame flags in cycle t+2.
// Backpressure: pause=1 in cycle c suppresses the read in cycle c+1; issued reads always complete.
// Ports: clock, reset (sync, active-high); bus (image_streamer_if.master) carries
//        start/base_addr/pause, the memory read port, the pixel stream and busy/done.
module image_streamer #(
    parameter int DATA_SIZE   = 8,
    parameter int ROW_SIZE    = 28,
    parameter int COLUMN_SIZE = 28,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic             clock,
    input  logic             reset,
    image_streamer_if.master bus
);

    localparam int CW = (ROW_SIZE > 1)    ? $clog2(ROW_SIZE)    : 1;
    localparam int RW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(COLUMN_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state;

    // Coordinates of the next pixel to be read; they return to 0 once the
    // final read of a frame is issued, so IDLE always starts at pixel (0,0).
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Stage 0: read request plus the flags of the pixel being read
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_row_last;
    logic                  rd_frame_last;

    // Stage 1: memory data returning this cycle
    logic                  s1_vld;
    logic                  s1_row_last;
    logic                  s1_frame_last;

    // Stage 2: output register
    logic                  px_vld;
    logic [DATA_SIZE-1:0]  px_dat;
    logic                  px_row_last;
    logic                  px_frame_last;

    logic                  busy_q;
    logic                  done_q;

    logic                  issue;
    logic                  at_row_end;
    logic                  at_frame_end;

    assign at_row_end   = (col == COL_LAST);
    assign at_frame_end = at_row_end && (row == ROW_LAST);

    // The first read of a frame is issued straight from IDLE and ignores pause;
    // inside the frame each un-paused cycle issues one read. DRAIN never issues.
    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = bus.start;
            STREAM:  issue = !bus.pause;
            default: issue = 1'b0;
        endcase
    end

    // Control FSM: owns the read request, the raster counters and busy/done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            rd_row_last   <= 1'b0;
            rd_frame_last <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rd_en         <= issue;
            rd_row_last   <= issue && at_row_end;
            rd_frame_last <= issue && at_frame_end;

            if (issue) begin
                // base_addr is captured only on the first read; the address
                // register then serves as the running frame pointer and holds
                // its value during paused cycles.
                rd_addr <= (state == IDLE) ? bus.base_addr : rd_addr + 1'b1;

                if (at_frame_end) begin
                    col <= '0;
                    row <= '0;
                end else if (at_row_end) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (issue) begin
                        busy_q <= 1'b1;
                        // A single-pixel frame is complete after its first read.
                        state  <= at_frame_end ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (issue && at_frame_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last pixel is in the output register this cycle, so
                    // returning to IDLE now lets a start coinciding with done
                    // issue its first read without a bubble.
                    if (px_vld && px_frame_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-stage data pipeline. The flags ride alongside the read strobe, so
    // they stay aligned with their pixel regardless of pause gaps, and they
    // are forced low whenever the stage carries no pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld        <= 1'b0;
            s1_row_last   <= 1'b0;
            s1_frame_last <= 1'b0;
            px_vld        <= 1'b0;
            px_dat        <= '0;
            px_row_last   <= 1'b0;
            px_frame_last <= 1'b0;
        end else begin
            s1_vld        <= rd_en;
            s1_row_last   <= rd_en && rd_row_last;
            s1_frame_last <= rd_en && rd_frame_last;

            px_vld        <= s1_vld;
            px_row_last   <= s1_vld && s1_row_last;
            px_frame_last <= s1_vld && s1_frame_last;
            if (s1_vld) begin
                px_dat <= bus.mem_rd_data;
            end
        end
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_addr    = rd_addr;
    assign bus.pixel_out   = px_dat;
    assign bus.pixel_valid = px_vld;
    assign bus.row_last    = px_row_last;
    assign bus.frame_last  = px_frame_last;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
